// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART receive-buffer constants
package uart_rx_fifo_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int RX_FIFO_DEPTH   = 16;
  localparam int RX_FIFO_AFULL   = 14;
  localparam int CLK_PERIOD_NS   = 8;
endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port DEPTH x DATA_WIDTH array, sync write and sync read
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read-before-write on a shared address: a full-FIFO push+pop must return the old entry.
  always_ff @(posedge clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte buffer between UART receiver and consumer, with sticky overrun
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = RX_FIFO_DEPTH,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  i_rx_dv,
  input  logic [DATA_WIDTH-1:0] i_rx_byte,
  input  logic                  i_rd_en,
  input  logic                  i_clr_overrun,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_overrun
);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C = (ADDR_W + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  have_data_q, have_data_d;
  logic                  wr_acc, rd_acc, drop;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign o_empty       = (count_q == '0);
  assign o_full        = (count_q == DEPTH_C);
  assign o_almost_full = (count_q >= AFULL_C);
  assign o_count       = count_q;
  assign o_overrun     = overrun_q;
  assign o_rd_valid    = rd_valid_q;
  // The array has no reset, so the output reads zero until the first successful pop.
  assign o_rd_data     = have_data_q ? mem_rd_data : '0;

  // A pop on a full buffer frees the slot, so the same-cycle write is kept.
  assign rd_acc = i_rd_en && !o_empty;
  assign wr_acc = i_rx_dv && (!o_full || rd_acc);
  assign drop   = i_rx_dv && o_full && !rd_acc;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overrun_d   = overrun_q;
    rd_valid_d  = rd_acc;
    have_data_d = have_data_q | rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop)               overrun_d = 1'b1;
    else if (i_clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      rd_valid_q  <= rd_valid_d;
      have_data_q <= have_data_d;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (sysclk),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_rx_byte),
    .i_rd_en   (rd_acc),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (mem_rd_data)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and random checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DEPTH = RX_FIFO_DEPTH;
  localparam int AFULL = RX_FIFO_AFULL;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       i_rd_en;
  logic       i_clr_overrun;
  logic [7:0] o_rd_data;
  logic       o_rd_valid, o_empty, o_full, o_almost_full, o_overrun;
  logic [4:0] o_count;

  int passed = 0;
  int total  = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovr   = 1'b0;

  always #(CLK_PERIOD_NS / 2) sysclk = ~sysclk;

  uart_rx_fifo dut (
    .sysclk        (sysclk),
    .rst_n         (rst_n),
    .i_rx_dv       (i_rx_dv),
    .i_rx_byte     (i_rx_byte),
    .i_rd_en       (i_rd_en),
    .i_clr_overrun (i_clr_overrun),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_count       (o_count),
    .o_overrun     (o_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"},    32'(o_count),       32'(n));
    chk({tag, ".empty"},    32'(o_empty),       32'(n == 0));
    chk({tag, ".full"},     32'(o_full),        32'(n == DEPTH));
    chk({tag, ".afull"},    32'(o_almost_full), 32'(n >= AFULL));
    chk({tag, ".overrun"},  32'(o_overrun),     32'(exp_ovr));
    chk({tag, ".rd_valid"}, 32'(o_rd_valid),    32'(exp_valid));
    chk({tag, ".rd_data"},  32'(o_rd_data),     32'(exp_data));
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks at the next falling edge.
  task automatic step(input string tag, input logic dv, input logic [7:0] b,
                      input logic rd, input logic clr);
    int  n;
    bit  popped;
    n = model_q.size();
    i_rx_dv = dv; i_rx_byte = b; i_rd_en = rd; i_clr_overrun = clr;
    popped = rd && (n > 0);
    if (popped) exp_data = model_q.pop_front();
    exp_valid = popped;
    if (dv && (n < DEPTH || popped)) model_q.push_back(b);
    if (dv && n == DEPTH && !popped) exp_ovr = 1'b1;
    else if (clr)                    exp_ovr = 1'b0;
    @(negedge sysclk);
    i_rx_dv = 1'b0; i_rd_en = 1'b0; i_clr_overrun = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic push(input string tag, input logic [7:0] b);
    step(tag, 1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_rd_en = 1'b0; i_clr_overrun = 1'b0;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    check_all("reset");
    repeat (3) idle("idle");

    push("t2w", 8'h0B); idle("t2i");
    push("t2w", 8'hA5); idle("t2i");
    push("t2w", 8'h3C); idle("t2i");
    repeat (3) pop("t2pop");
    idle("t2end");

    for (int i = 0; i < 16; i++) push("t3fill", 8'(i));
    push("t3drop", 8'hFF);
    idle("t3hold");
    for (int i = 0; i < 16; i++) pop("t3drain");
    idle("t3sticky");
    step("t3clr", 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) push("t4fill", 8'($urandom));
    step("t4both", 1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) pop("t4drain");
    chk("t4last", 32'(o_rd_data), 32'h77);

    step("t5both", 1'b1, 8'h5A, 1'b1, 1'b0);
    pop("t5pop");
    chk("t5data", 32'(o_rd_data), 32'h5A);

    for (int i = 0; i < 20; i++) step("t6mix", 1'b1, 8'($urandom), (i % 4) != 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6rst.count",    32'(o_count),    32'd0);
    chk("t6rst.rd_valid", 32'(o_rd_valid), 32'd0);
    chk("t6rst.empty",    32'(o_empty),    32'd1);
    chk("t6rst.rd_data",  32'(o_rd_data),  32'd0);
    model_q.delete();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge sysclk);
    check_all("t6post");

    for (int i = 0; i < 300; i++)
      step("rndfill", ($urandom % 10) < 7, 8'($urandom), ($urandom % 10) < 3, ($urandom % 8) == 0);
    for (int i = 0; i < 300; i++)
      step("rnddrain", ($urandom % 10) < 3, 8'($urandom), ($urandom % 10) < 7, ($urandom % 8) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
